cavlc_rbsp_window: RTL
======================

// Module: cavlc_rbsp_window
// PURPOSE
//  Parametrised bitstream front end for the CAVLC residual decoder. Accepts packed RBSP words over a
//  valid/ready handshake and presents a left-aligned look-ahead window (rbsp[0] = next unread bit).
//  The decoder consumes a variable number of bits (its len_comb) per cycle. Supports byte alignment,
//  flush and underflow detection. Replaces the fixed 16-bit feed with configurable input and window widths.
// PARAMETERS
//  IN_W   32  input word width in bits (multiple of 8)
//  WIN_W  16  look-ahead window width presented to the decoder
//  LEN_W  5   width of the consume-length port
//  BUF_W  64  holding buffer depth in bits; must be >= IN_W + WIN_W
// PORTS
//  clk         in   1                 clock, rising edge
//  rst         in   1                 asynchronous, active-high reset
//  ena         in   1                 global enable; all state holds when low
//  flush       in   1                 synchronous clear of buffer, bit_pos and error
//  in_data     in   IN_W              input word; MSB is the earliest bit
//  in_valid    in   1                 in_data valid
//  in_ready    out  1                 block can take a word this cycle
//  rbsp        out  [0:WIN_W-1]       window, left-aligned; bits beyond bits_avail read 0
//  win_valid   out  1                 bits_avail >= WIN_W
//  consume     in   1                 drop len bits this cycle
//  len         in   LEN_W             bits to drop (0..WIN_W)
//  align       in   1                 discard up to the next byte boundary of bit_pos
//  bits_avail  out  $clog2(BUF_W+1)   valid bits held
//  bit_pos     out  32                total bits consumed since reset/flush; wraps modulo 2^32
//  err_underflow out 1                sticky: a consume or align asked for more bits than were held
// BEHAVIOUR
//  Reset (async, rst=1): buffer=0, bits_avail=0, bit_pos=0, err_underflow=0, rbsp=0, win_valid=0.
//   in_ready is combinational and reads 1 as soon as reset is released with ena=1.
//  in_ready = ena & ~flush & (bits_avail + IN_W <= BUF_W). It uses the registered count only;
//   a same-cycle consume never raises in_ready.
//  Per-cycle update order when ena=1 and flush=0:
//   1. consume: if consume and len<=bits_avail, shift left by len, bits_avail-=len, bit_pos+=len.
//      If len>bits_avail: set err_underflow, clear buffer, bits_avail=0, and leave bit_pos unchanged.
//      len=0 is a no-op.
//   2. align: pad=(8-bit_pos'[2:0])&7, where bit_pos' is bit_pos after step 1. Shift out pad bits and
//      add pad to bit_pos. If pad exceeds the remaining bits, treat it as underflow (same action as step 1).
//   3. append: if in_valid & in_ready, write in_data immediately after the remaining bits;
//      bits_avail+=IN_W.
//  flush (ena=1): highest priority. Clears buffer, bits_avail, bit_pos and err_underflow; all other
//   inputs are ignored that cycle.
//  ena=0: no state changes. in_ready=0. consume, align and in_valid are ignored.
//  Latency: an accepted word and a consume are both reflected in rbsp/bits_avail on the next cycle.
//   rbsp, win_valid and bits_avail are register outputs, with no input-to-output combinational path.
//  Bits below bits_avail are always zero-filled. Buffer contents are never read beyond BUF_W.
//  err_underflow clears only on rst or flush.
// TESTING
//  1. Reset, then release with ena=1 -> rbsp=16'h0000, win_valid=0, bits_avail=0, in_ready=1.
//  2. Push 32'hDEADBEEF -> next cycle: rbsp=16'hDEAD, bits_avail=32, win_valid=1.
//  3. Consume len=4 -> rbsp=16'hEADB, bit_pos=4, bits_avail=28. Then align -> rbsp=16'hADBE,
//     bit_pos=8, bits_avail=24.
//  4. Start at bits_avail=32; push plus consume len=16 in the same cycle -> bits_avail=48 and
//     in_ready=0. Keep in_valid=1 plus consume 16 -> word refused, in_ready=1 the following cycle.
//  5. Start at bits_avail=3; consume len=5 -> err_underflow=1, bits_avail=0, bit_pos unchanged.
//     Flush -> err_underflow=0.
//  6. Assert rst mid-stream with bits_avail=40 -> all outputs zero immediately, without a clock edge.

Source files
------------

// File: rtl/cavlc_rbsp_window.sv
// cavlc_rbsp_window
//   Bitstream front end for the CAVLC residual decoder. Packed RBSP words
//   are appended to a left-aligned holding buffer. The top WIN_W bits are
//   shown to the decoder as a look-ahead window, where rbsp[0] is the next
//   unread bit. Each cycle the decoder may drop a variable number of bits.
//   It may also skip forward to the next byte boundary of the consumed-bit
//   count.
// Ports
//   clk, rst       rising-edge clock; asynchronous active-high reset
//   ena            global enable; all state holds and in_ready is 0 when low
//   flush          synchronous clear of buffer, bit_pos and err_underflow
//   in_data/valid  input word, MSB is the earliest bit
//   in_ready       combinational; space for one more word in the buffer
//   rbsp           left-aligned window; bits beyond bits_avail read 0
//   win_valid      a full window of valid bits is held
//   consume/len    drop len bits this cycle (0..WIN_W)
//   align          drop bits up to the next byte boundary of bit_pos
//   bits_avail     valid bits held
//   bit_pos        bits consumed since reset/flush, wraps modulo 2^32
//   err_underflow  sticky; a consume or align asked for more than was held
module cavlc_rbsp_window #(
  parameter  int IN_W  = 32,
  parameter  int WIN_W = 16,
  parameter  int LEN_W = 5,
  parameter  int BUF_W = 64,
  localparam int CW    = $clog2(BUF_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             flush,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:WIN_W-1] rbsp,
  output logic             win_valid,
  input  logic             consume,
  input  logic [LEN_W-1:0] len,
  input  logic             align,
  output logic [CW-1:0]    bits_avail,
  output logic [31:0]      bit_pos,
  output logic             err_underflow
);

  // MSB of buf_q is the next unread bit. Bits at or below the valid count
  // are kept at zero, so an append can simply OR the new word in.
  logic [BUF_W-1:0] buf_q, buf_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [31:0]      pos_q, pos_n;
  logic             err_q, err_n;
  logic [2:0]       pad;
  logic [BUF_W-1:0] word_ext;

  // Uses only the registered count. A same-cycle consume never opens space.
  assign in_ready = ~rst & ena & ~flush & ((32'(cnt_q) + 32'(IN_W)) <= 32'(BUF_W));

  assign word_ext = {in_data, {(BUF_W-IN_W){1'b0}}};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    buf_n = buf_q;
    cnt_n = cnt_q;
    pos_n = pos_q;
    err_n = err_q;
    pad   = '0;
    if (ena) begin
      if (flush) begin
        buf_n = '0;
        cnt_n = '0;
        pos_n = '0;
        err_n = 1'b0;
      end else begin
        if (consume && len != '0) begin
          if (32'(len) <= 32'(cnt_n)) begin
            buf_n = buf_n << len;
            cnt_n = cnt_n - CW'(len);
            pos_n = pos_n + 32'(len);
          end else begin
            err_n = 1'b1;
            buf_n = '0;
            cnt_n = '0;
          end
        end
        // (8 - pos[2:0]) & 7 is the same value as -pos[2:0] in 3 bits.
        pad = 3'd0 - pos_n[2:0];
        if (align && pad != 3'd0) begin
          if (32'(pad) <= 32'(cnt_n)) begin
            buf_n = buf_n << pad;
            cnt_n = cnt_n - CW'(pad);
            pos_n = pos_n + 32'(pad);
          end else begin
            err_n = 1'b1;
            buf_n = '0;
            cnt_n = '0;
          end
        end
        // cnt_n cannot exceed cnt_q here, and in_ready ensures cnt_q + IN_W fits.
        if (in_valid && in_ready) begin
          buf_n = buf_n | (word_ext >> cnt_n);
          cnt_n = cnt_n + CW'(IN_W);
        end
      end
    end
  end

  // NOTE: the buffer is reset along with the counters. Stale bits would
  // otherwise appear in the window and break the zero-fill invariant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments only.
      buf_q <= '0;
      cnt_q <= '0;
      pos_q <= '0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_n;
      cnt_q <= cnt_n;
      pos_q <= pos_n;
      err_q <= err_n;
    end
  end

  assign rbsp          = buf_q[BUF_W-1 -: WIN_W];
  assign win_valid     = (32'(cnt_q) >= 32'(WIN_W));
  assign bits_avail    = cnt_q;
  assign bit_pos       = pos_q;
  assign err_underflow = err_q;

endmodule
